control_unit_sequencer: RTL
===========================

CONTROL_UNIT_SEQUENCER -- requirements
Module: control_unit_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: Clock input 1 (rising-edge, the only clock), then Reset input 1 (active-high, sampled only on the Clock edge).
REQ-002 The block SHALL provide the input IROut (16 bits): the current instruction register contents.
REQ-003 The block SHALL provide the input ALUOutFlag (4 bits): {Z,C,N,O} from the ALU flag register.
REQ-004 The block SHALL provide these register-file control outputs: RF_OutASel (3), RF_OutBSel (3), RF_FunSel (3), RF_RegSel (4), RF_ScrSel (4).
REQ-005 The block SHALL provide these ALU control outputs: ALU_FunSel (5) and ALU_WF (1).
REQ-006 The block SHALL provide these address-register-file control outputs: ARF_OutCSel (2), ARF_OutDSel (2), ARF_FunSel (2), ARF_RegSel (5).
REQ-007 The block SHALL provide these IR, memory and mux control outputs: IR_LH, IR_Write, Mem_WR, Mem_CS (1 each); MuxASel, MuxBSel, DR_FunSel (2 each); MuxCSel, MuxDSel, DR_E (1 each).
REQ-008 The block SHALL provide two status outputs: T (3 bits), the current sequence step; Halted (1 bit), high in HALT.

Function
REQ-009 Idle values (every output not named in a step) SHALL be: all RegSel/ScrSel enables 0 (hold), IR_Write=0, DR_E=0, ALU_WF=0, Mem_CS=1 (deselected), Mem_WR=0 (read), all other selects 0.
REQ-010 T0 (FETCH_L) SHALL drive: ARF_OutDSel=PC, Mem_CS=0, IR_Write=1, IR_LH=0, ARF_RegSel=PC, ARF_FunSel=INC.
REQ-011 T1 (FETCH_H) SHALL drive the same values as T0 except IR_LH=1.
REQ-012 The T2 step SHALL decode the opcode from IROut[15:10].
REQ-013 BRA (0x00) SHALL, in T2, load PC with zero-extended IROut[7:0] (MuxBSel=IR, ARF_FunSel=LOAD) and return to T0.
REQ-014 BNE (0x01) and BEQ (0x02) SHALL perform the BRA action in T2 only if Z=0 (BNE) or Z=1 (BEQ); otherwise they drive idle values; both return to T0.
REQ-015 ALU (0x03) SHALL, in T2, drive: RF_OutASel={1'b0,IROut[6:5]}, RF_OutBSel={1'b0,IROut[4:3]}, ALU_FunSel={2'b00,IROut[2:0]}, ALU_WF=IROut[9], MuxASel=ALU, RF_FunSel=LOAD, RF_RegSel one-hot on IROut[8:7]; then return to T0.
REQ-016 LDR (0x04) SHALL, in T2, drive ARF_OutDSel=AR, Mem_CS=0, Mem_WR=0, MuxASel=MEM, and load Rd=IROut[8:7]; in T3 it SHALL drive ARF_RegSel=AR, ARF_FunSel=INC; then return to T0.
REQ-017 STR (0x05) SHALL, in T2, drive ARF_OutDSel=AR, RF_OutASel=IROut[8:7], MuxCSel=0, Mem_CS=0, Mem_WR=1; then return to T0.
REQ-018 HLT (0x3F) SHALL enter HALT from T2: Halted=1, idle values, T frozen at 2, exited only by Reset.
REQ-019 Undefined opcodes SHALL behave per REQ-024.
REQ-020 T SHALL advance by exactly 1 per cycle and be cleared to 0 at the end of each instruction.
REQ-021 Branch flags SHALL be sampled from ALUOutFlag in T2 and no earlier.

Reset
REQ-022 On Reset=1 at a Clock edge, the block SHALL set T=0 and Halted=0, abort any step mid-instruction, and drive the T0 values on the next cycle.
REQ-023 While Reset=1, all outputs SHALL be at idle values; no RF, ARF or memory write enable is asserted.

Configuration
REQ-024 Macro CU_ILLEGAL_TRAP_EN: when defined, an undefined opcode in T2 SHALL enter HALT and set output Illegal (1 bit, cleared by Reset); when undefined, the port SHALL be absent and an undefined opcode SHALL act as a NOP (idle T2, return to T0).

Structure
REQ-025 Shared package cu_pkg SHALL hold the opcode constants, the FETCH_L/FETCH_H/EXEC/HALT state encoding, and the select/function codes (PC, AR, INC, LOAD, ALU, MEM, IR).
REQ-026 The block SHALL contain one sub-module, seq_counter: a 3-bit counter with synchronous clear and hold inputs, driving T.

Verification
REQ-027 Reset then 2 clocks: cycle 1 SHALL give T=0, IR_Write=1, IR_LH=0, ARF_FunSel=INC; cycle 2 SHALL give T=1, IR_LH=1.
REQ-028 IROut=16'h0042 (BRA) in T2: SHALL give ARF_FunSel=LOAD on PC, with T=0 next cycle.
REQ-029 IROut=16'h0410 (BNE), Z=1: T2 SHALL show no PC load; with Z=0, T2 SHALL show a PC load.
REQ-030 IROut=16'h0E9D (ALU, S=1, Rd=1, Rs1=0, Rs2=3, fn=5): T2 SHALL give RF_RegSel=4'b0010, RF_OutBSel=3, ALU_FunSel=5'b00101, ALU_WF=1.
REQ-031 IROut=16'hFC00 (HLT): T2 onward SHALL give Halted=1 and idle outputs for 10 cycles; Reset SHALL clear Halted.
REQ-032 LDR with Reset asserted in T2: next cycle SHALL give T=0 with no AR increment ever issued.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared definitions for the control unit sequencer: opcodes, state
// encoding, select/function codes and the bundled control-word struct.
package cu_pkg;

    // Opcodes decoded from IROut[15:10]
    localparam logic [5:0] OP_BRA = 6'h00;
    localparam logic [5:0] OP_BNE = 6'h01;
    localparam logic [5:0] OP_BEQ = 6'h02;
    localparam logic [5:0] OP_ALU = 6'h03;
    localparam logic [5:0] OP_LDR = 6'h04;
    localparam logic [5:0] OP_STR = 6'h05;
    localparam logic [5:0] OP_HLT = 6'h3F;

    typedef enum logic [1:0] {
        FETCH_L = 2'd0,
        FETCH_H = 2'd1,
        EXEC    = 2'd2,
        HALT    = 2'd3
    } cu_state_t;

    // Address register file selects / functions
    localparam logic [1:0] ARF_D_PC     = 2'b00;
    localparam logic [1:0] ARF_D_AR     = 2'b10;
    localparam logic [4:0] ARF_REG_PC   = 5'b00001;
    localparam logic [4:0] ARF_REG_AR   = 5'b00100;
    localparam logic [1:0] ARF_FUN_INC  = 2'b01;
    localparam logic [1:0] ARF_FUN_LOAD = 2'b10;

    // Register file function and datapath mux codes
    localparam logic [2:0] RF_FUN_LOAD  = 3'b010;
    localparam logic [1:0] MUXA_ALU     = 2'b00;
    localparam logic [1:0] MUXA_MEM     = 2'b01;
    localparam logic [1:0] MUXB_IR      = 2'b01;

    typedef struct packed {
        logic [2:0] rf_out_a_sel;
        logic [2:0] rf_out_b_sel;
        logic [2:0] rf_fun_sel;
        logic [3:0] rf_reg_sel;
        logic [3:0] rf_scr_sel;
        logic [4:0] alu_fun_sel;
        logic       alu_wf;
        logic [1:0] arf_out_c_sel;
        logic [1:0] arf_out_d_sel;
        logic [1:0] arf_fun_sel;
        logic [4:0] arf_reg_sel;
        logic       ir_lh;
        logic       ir_write;
        logic       mem_wr;
        logic       mem_cs;
        logic [1:0] mux_a_sel;
        logic [1:0] mux_b_sel;
        logic [1:0] dr_fun_sel;
        logic       mux_c_sel;
        logic       mux_d_sel;
        logic       dr_e;
    } cu_ctrl_t;

    // Quiescent control word: nothing written, memory deselected
    function automatic cu_ctrl_t ctrl_idle();
        cu_ctrl_t c;
        c        = '0;
        c.mem_cs = 1'b1;
        return c;
    endfunction

    function automatic logic [3:0] rf_onehot(input logic [1:0] r);
        return 4'b0001 << r;
    endfunction

    function automatic logic op_defined(input logic [5:0] op);
        return (op <= OP_STR) || (op == OP_HLT);
    endfunction

endpackage

// File: rtl/control_unit_sequencer_seq_counter.sv
// Step counter T: synchronous clear has priority over hold.
module seq_counter (
    input  logic       clk,
    input  logic       clr,
    input  logic       hold,
    output logic [2:0] count
);

    // Clear ends an instruction, hold freezes T while halted
    always_ff @(posedge clk) begin
        if (clr)
            count <= 3'd0;
        else if (!hold)
            count <= count + 3'd1;
    end

endmodule

// File: rtl/control_unit_sequencer.sv
// Hardwired control unit sequencer: two-step fetch, then opcode decode in T2
// (LDR also uses T3). Optional macro CU_ILLEGAL_TRAP_EN makes undefined
// opcodes halt and raise Illegal; by default they execute as NOPs.
module control_unit_sequencer
    import cu_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] IROut,
    input  logic [3:0]  ALUOutFlag,
    output logic [2:0]  RF_OutASel,
    output logic [2:0]  RF_OutBSel,
    output logic [2:0]  RF_FunSel,
    output logic [3:0]  RF_RegSel,
    output logic [3:0]  RF_ScrSel,
    output logic [4:0]  ALU_FunSel,
    output logic        ALU_WF,
    output logic [1:0]  ARF_OutCSel,
    output logic [1:0]  ARF_OutDSel,
    output logic [1:0]  ARF_FunSel,
    output logic [4:0]  ARF_RegSel,
    output logic        IR_LH,
    output logic        IR_Write,
    output logic        Mem_WR,
    output logic        Mem_CS,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic [1:0]  DR_FunSel,
    output logic        MuxCSel,
    output logic        MuxDSel,
    output logic        DR_E,
    output logic [2:0]  T,
    output logic        Halted
`ifdef CU_ILLEGAL_TRAP_EN
   ,output logic        Illegal
`endif
);

    cu_state_t  state;
    cu_ctrl_t   ctl;
    logic [5:0] op;
    logic       flag_z;
    logic       in_t2;
    logic       in_t3;
    logic       illegal_op;
    logic       enter_halt;
    logic       instr_done;
    logic       take_branch;
    logic       unused_flags;

    assign op           = IROut[15:10];
    assign flag_z       = ALUOutFlag[3];
    assign unused_flags = ^ALUOutFlag[2:0];
    assign in_t2        = (state == EXEC) && (T == 3'd2);
    assign in_t3        = (state == EXEC) && (T == 3'd3);

`ifdef CU_ILLEGAL_TRAP_EN
    assign illegal_op = in_t2 && !op_defined(op);
`else
    assign illegal_op = 1'b0;
`endif

    assign enter_halt  = (in_t2 && (op == OP_HLT)) || illegal_op;
    // Every opcode except LDR finishes in T2; LDR finishes in T3
    assign instr_done  = (in_t2 && !enter_halt && (op != OP_LDR)) || in_t3;
    // Z is looked at only here, so only its T2 value matters
    assign take_branch = (op == OP_BRA) ||
                         ((op == OP_BNE) && !flag_z) ||
                         ((op == OP_BEQ) &&  flag_z);

    seq_counter u_seq_counter (
        .clk   (Clock),
        .clr   (Reset | instr_done),
        .hold  ((state == HALT) | enter_halt),
        .count (T)
    );

    // Sequencer state plus the sticky halt/illegal status bits
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state  <= FETCH_L;
            Halted <= 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
            Illegal <= 1'b0;
`endif
        end else begin
            case (state)
                FETCH_L: state <= FETCH_H;
                FETCH_H: state <= EXEC;
                EXEC: begin
                    if (enter_halt) begin
                        state  <= HALT;
                        Halted <= 1'b1;
                    end else if (instr_done) begin
                        state <= FETCH_L;
                    end
                end
                HALT:    state <= HALT;
                default: state <= FETCH_L;
            endcase
`ifdef CU_ILLEGAL_TRAP_EN
            if (illegal_op)
                Illegal <= 1'b1;
`endif
        end
    end

    // Control word decode; forced idle while Reset is held
    always_comb begin
        ctl = ctrl_idle();
        if (!Reset) begin
            case (state)
                FETCH_L, FETCH_H: begin
                    ctl.arf_out_d_sel = ARF_D_PC;
                    ctl.mem_cs        = 1'b0;
                    ctl.ir_write      = 1'b1;
                    ctl.ir_lh         = (state == FETCH_H);
                    ctl.arf_reg_sel   = ARF_REG_PC;
                    ctl.arf_fun_sel   = ARF_FUN_INC;
                end
                EXEC: begin
                    if (in_t2) begin
                        case (op)
                            OP_BRA, OP_BNE, OP_BEQ: begin
                                if (take_branch) begin
                                    ctl.mux_b_sel   = MUXB_IR;
                                    ctl.arf_fun_sel = ARF_FUN_LOAD;
                                    ctl.arf_reg_sel = ARF_REG_PC;
                                end
                            end
                            OP_ALU: begin
                                ctl.rf_out_a_sel = {1'b0, IROut[6:5]};
                                ctl.rf_out_b_sel = {1'b0, IROut[4:3]};
                                ctl.alu_fun_sel  = {2'b00, IROut[2:0]};
                                ctl.alu_wf       = IROut[9];
                                ctl.mux_a_sel    = MUXA_ALU;
                                ctl.rf_fun_sel   = RF_FUN_LOAD;
                                ctl.rf_reg_sel   = rf_onehot(IROut[8:7]);
                            end
                            OP_LDR: begin
                                ctl.arf_out_d_sel = ARF_D_AR;
                                ctl.mem_cs        = 1'b0;
                                ctl.mem_wr        = 1'b0;
                                ctl.mux_a_sel     = MUXA_MEM;
                                ctl.rf_fun_sel    = RF_FUN_LOAD;
                                ctl.rf_reg_sel    = rf_onehot(IROut[8:7]);
                            end
                            OP_STR: begin
                                ctl.arf_out_d_sel = ARF_D_AR;
                                ctl.rf_out_a_sel  = {1'b0, IROut[8:7]};
                                ctl.mux_c_sel     = 1'b0;
                                ctl.mem_cs        = 1'b0;
                                ctl.mem_wr        = 1'b1;
                            end
                            default: ;
                        endcase
                    end else if (in_t3) begin
                        ctl.arf_reg_sel = ARF_REG_AR;
                        ctl.arf_fun_sel = ARF_FUN_INC;
                    end
                end
                default: ;
            endcase
        end
    end

    assign RF_OutASel  = ctl.rf_out_a_sel;
    assign RF_OutBSel  = ctl.rf_out_b_sel;
    assign RF_FunSel   = ctl.rf_fun_sel;
    assign RF_RegSel   = ctl.rf_reg_sel;
    assign RF_ScrSel   = ctl.rf_scr_sel;
    assign ALU_FunSel  = ctl.alu_fun_sel;
    assign ALU_WF      = ctl.alu_wf;
    assign ARF_OutCSel = ctl.arf_out_c_sel;
    assign ARF_OutDSel = ctl.arf_out_d_sel;
    assign ARF_FunSel  = ctl.arf_fun_sel;
    assign ARF_RegSel  = ctl.arf_reg_sel;
    assign IR_LH       = ctl.ir_lh;
    assign IR_Write    = ctl.ir_write;
    assign Mem_WR      = ctl.mem_wr;
    assign Mem_CS      = ctl.mem_cs;
    assign MuxASel     = ctl.mux_a_sel;
    assign MuxBSel     = ctl.mux_b_sel;
    assign DR_FunSel   = ctl.dr_fun_sel;
    assign MuxCSel     = ctl.mux_c_sel;
    assign MuxDSel     = ctl.mux_d_sel;
    assign DR_E        = ctl.dr_e;

endmodule
